// File: rtl/keypad_entry.sv
// 4x4 matrix keypad scanner, debouncer and signed decimal entry with valid/ack delivery.
// Optional auto-repeat of held digit/backspace keys is enabled with KEYPAD_AUTOREPEAT_EN.
module keypad_entry #(
  parameter logic [15:0] SCAN_DIV     = 16'd50000,
  parameter logic [19:0] DEBOUNCE_CNT = 20'd500000,
  parameter int          MAX_DIGITS   = 4
`ifdef KEYPAD_AUTOREPEAT_EN
  ,
  parameter logic [25:0] REPEAT_DLY   = 26'd25000000,
  parameter logic [25:0] REPEAT_RATE  = 26'd5000000
`endif
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [3:0]  key_col,
  output logic [3:0]  key_row,
  input  logic        data_ack,
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic [15:0] entry_bcd,
  output logic        entry_neg,
  output logic [2:0]  digit_cnt
);

  localparam logic [2:0] MAX_DIGITS_W = 3'(MAX_DIGITS);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, RELEASE} scan_state_t;

  scan_state_t state_reg;
  logic [3:0]  col_meta_reg;
  logic [3:0]  col_s_reg;
  logic [1:0]  row_idx_reg;
  logic [3:0]  key_row_reg;
  logic [15:0] div_cnt_reg;
  logic [19:0] deb_cnt_reg;
  logic [3:0]  pat_reg;
  logic [1:0]  key_r_reg;
  logic [1:0]  key_c_reg;
  logic        armed_reg;
  logic [1:0]  clean_rows_reg;
  logic        key_event_reg;

  logic [31:0] data_out_reg;
  logic        data_valid_reg;
  logic [15:0] entry_bcd_reg;
  logic        entry_neg_reg;
  logic [2:0]  digit_cnt_reg;

  logic [3:0]  col_low;
  logic        one_low;
  logic [1:0]  col_idx;
  logic [1:0]  row_idx_next;

  logic        key_is_digit;
  logic        key_is_bksp;
  logic        key_is_sign;
  logic        key_is_clear;
  logic        key_is_enter;
  logic [3:0]  key_digit;

  logic [31:0] digit_val [4];
  logic [31:0] mag;
  logic [31:0] value;

  assign key_row    = key_row_reg;
  assign data_out   = data_out_reg;
  assign data_valid = data_valid_reg;
  assign entry_bcd  = entry_bcd_reg;
  assign entry_neg  = entry_neg_reg;
  assign digit_cnt  = digit_cnt_reg;

  assign col_low      = ~col_s_reg;
  assign one_low      = (col_low != 4'd0) && ((col_low & (col_low - 4'd1)) == 4'd0);
  assign row_idx_next = row_idx_reg + 2'd1;

  always_comb begin
    col_idx = 2'd0;
    case (col_low)
      4'b0010: col_idx = 2'd1;
      4'b0100: col_idx = 2'd2;
      4'b1000: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
  end

  // Column 3 holds the letter keys, row 3 holds * 0 #; everything else is 1..9.
  always_comb begin
    key_is_digit = 1'b0;
    key_is_bksp  = 1'b0;
    key_is_sign  = 1'b0;
    key_is_clear = 1'b0;
    key_is_enter = 1'b0;
    key_digit    = 4'd0;
    if (key_c_reg == 2'd3) begin
      key_is_sign  = (key_r_reg == 2'd0);
      key_is_clear = (key_r_reg == 2'd2);
    end else if (key_r_reg == 2'd3) begin
      case (key_c_reg)
        2'd0:    key_is_bksp  = 1'b1;
        2'd1:    key_is_digit = 1'b1;
        default: key_is_enter = 1'b1;
      endcase
    end else begin
      key_is_digit = 1'b1;
      key_digit    = {2'b00, key_r_reg} * 4'd3 + {2'b00, key_c_reg} + 4'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      localparam logic [31:0] WEIGHT = (gi == 0) ? 32'd1 : (gi == 1) ? 32'd10 :
                                       (gi == 2) ? 32'd100 : 32'd1000;
      assign digit_val[gi] = {28'd0, entry_bcd_reg[gi*4 +: 4]} * WEIGHT;
    end
  endgenerate

  assign mag   = digit_val[0] + digit_val[1] + digit_val[2] + digit_val[3];
  assign value = entry_neg_reg ? (32'd0 - mag) : mag;

`ifdef KEYPAD_AUTOREPEAT_EN
  logic [25:0] rep_cnt_reg;
  logic        rep_phase_reg;
  logic        key_repeatable;
  logic [25:0] rep_limit;

  assign key_repeatable = key_is_digit | key_is_bksp;
  assign rep_limit      = (rep_phase_reg ? REPEAT_RATE : REPEAT_DLY) - 26'd1;
`endif

  // A key found held before one clean sweep after reset is waited out in RELEASE
  // without an event, so only a fresh press after reset is ever reported.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg      <= SCAN;
      col_meta_reg   <= 4'hF;
      col_s_reg      <= 4'hF;
      row_idx_reg    <= 2'd0;
      key_row_reg    <= 4'b1110;
      div_cnt_reg    <= 16'd0;
      deb_cnt_reg    <= 20'd0;
      pat_reg        <= 4'hF;
      key_r_reg      <= 2'd0;
      key_c_reg      <= 2'd0;
      armed_reg      <= 1'b0;
      clean_rows_reg <= 2'd0;
      key_event_reg  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_reg    <= 26'd0;
      rep_phase_reg  <= 1'b0;
`endif
    end else begin
      col_meta_reg  <= key_col;
      col_s_reg     <= col_meta_reg;
      key_event_reg <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      if (state_reg != RELEASE) begin
        rep_cnt_reg   <= 26'd0;
        rep_phase_reg <= 1'b0;
      end
`endif
      case (state_reg)
        SCAN: begin
          if (div_cnt_reg == SCAN_DIV - 16'd1) begin
            div_cnt_reg <= 16'd0;
            if (one_low) begin
              pat_reg     <= col_s_reg;
              key_r_reg   <= row_idx_reg;
              key_c_reg   <= col_idx;
              deb_cnt_reg <= 20'd0;
              state_reg   <= armed_reg ? DEBOUNCE : RELEASE;
            end else begin
              row_idx_reg <= row_idx_next;
              key_row_reg <= ~(4'b0001 << row_idx_next);
              if (col_s_reg != 4'hF) begin
                clean_rows_reg <= 2'd0;
              end else if (clean_rows_reg == 2'd3) begin
                armed_reg <= 1'b1;
              end else begin
                clean_rows_reg <= clean_rows_reg + 2'd1;
              end
            end
          end else begin
            div_cnt_reg <= div_cnt_reg + 16'd1;
          end
        end

        DEBOUNCE: begin
          if (col_s_reg != pat_reg) begin
            div_cnt_reg <= 16'd0;
            state_reg   <= SCAN;
          end else if (deb_cnt_reg == DEBOUNCE_CNT - 20'd1) begin
            key_event_reg <= 1'b1;
            deb_cnt_reg   <= 20'd0;
            state_reg     <= RELEASE;
          end else begin
            deb_cnt_reg <= deb_cnt_reg + 20'd1;
          end
        end

        RELEASE: begin
          if (col_s_reg != 4'hF) begin
            deb_cnt_reg <= 20'd0;
          end else if (deb_cnt_reg == DEBOUNCE_CNT - 20'd1) begin
            deb_cnt_reg <= 20'd0;
            div_cnt_reg <= 16'd0;
            armed_reg   <= 1'b1;
            state_reg   <= SCAN;
          end else begin
            deb_cnt_reg <= deb_cnt_reg + 20'd1;
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          if (armed_reg && key_repeatable && (col_s_reg == pat_reg)) begin
            if (rep_cnt_reg == rep_limit) begin
              key_event_reg <= 1'b1;
              rep_cnt_reg   <= 26'd0;
              rep_phase_reg <= 1'b1;
            end else begin
              rep_cnt_reg <= rep_cnt_reg + 26'd1;
            end
          end else begin
            rep_cnt_reg   <= 26'd0;
            rep_phase_reg <= 1'b0;
          end
`endif
        end

        default: state_reg <= SCAN;
      endcase
    end
  end

  // A load in the same cycle as an ack takes priority over the valid clear.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      data_out_reg   <= 32'd0;
      data_valid_reg <= 1'b0;
      entry_bcd_reg  <= 16'd0;
      entry_neg_reg  <= 1'b0;
      digit_cnt_reg  <= 3'd0;
    end else begin
      if (data_valid_reg && data_ack) begin
        data_valid_reg <= 1'b0;
      end
      if (key_event_reg) begin
        if (key_is_digit) begin
          if (digit_cnt_reg < MAX_DIGITS_W) begin
            entry_bcd_reg <= {entry_bcd_reg[11:0], key_digit};
            digit_cnt_reg <= digit_cnt_reg + 3'd1;
          end
        end else if (key_is_bksp) begin
          if (digit_cnt_reg != 3'd0) begin
            entry_bcd_reg <= entry_bcd_reg >> 4;
            digit_cnt_reg <= digit_cnt_reg - 3'd1;
          end
        end else if (key_is_sign) begin
          entry_neg_reg <= ~entry_neg_reg;
        end else if (key_is_clear) begin
          entry_bcd_reg <= 16'd0;
          entry_neg_reg <= 1'b0;
          digit_cnt_reg <= 3'd0;
        end else if (key_is_enter) begin
          if (!data_valid_reg || data_ack) begin
            data_out_reg   <= value;
            data_valid_reg <= 1'b1;
            entry_bcd_reg  <= 16'd0;
            entry_neg_reg  <= 1'b0;
            digit_cnt_reg  <= 3'd0;
          end
        end
      end
    end
  end

endmodule
